mul32_seq_ctrl: RTL and testbench
=================================

# mul32_seq_ctrl

Multi-cycle 32×32→64 multiplier controller for the phase-1 ALU. It produces HI/LO for MUL by time-sharing one 32-bit adder across all its steps: operand negation, 32 shift-add iterations, and result negation. It sits beside the ALU adder path and hands HI/LO to the register-file write-back.

## Interface
- `SIGNED_SUPPORT`, default 1: when 0, `signed_op` is ignored and every operation is unsigned.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `clr_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1: request; accepted only while `busy`=0.
- `signed_op`  in  1: operands are two's complement; sampled with `start`.
- `a`  in  32: multiplicand; sampled with `start`.
- `b`  in  32: multiplier; sampled with `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse; `hi`/`lo` are valid in this cycle.
- `hi`  out  32: product bits [63:32], taken from the `acc_hi` register.
- `lo`  out  32: product bits [31:0], taken from the `lo_q` register.

## Operation
- Registers:
  - `mcand`[31:0]
  - `acc_hi`[31:0]
  - `lo_q`[31:0] (multiplier, then product low)
  - `cnt`[5:0]
  - flags `neg_a`, `neg_b`, `neg_p`
  - `c_q` (saved carry)
- One adder instance with inputs `add_a`, `add_b`, `add_cin` and outputs `sum`, `cout`. The inputs are muxed by state; in IDLE/DONE they are 0.
- **IDLE**, when `start`=1:
  - Load: `mcand`←`a`, `lo_q`←`b`, `acc_hi`←0, `cnt`←0.
  - Let `s` = `signed_op` & `SIGNED_SUPPORT`.
  - Flags: `neg_a`←`s`&`a[31]`, `neg_b`←`s`&`b[31]`, `neg_p`←`neg_a`^`neg_b` (using the new flag values).
  - Next state: NEG_A if `neg_a`, else NEG_B if `neg_b`, else MUL.
- **NEG_A**: adder computes ~`mcand`+0+1; `mcand`←`sum`. Next state: NEG_B if `neg_b`, else MUL.
- **NEG_B**: adder computes ~`lo_q`+0+1; `lo_q`←`sum`. Next state: MUL.
- **MUL**: adder computes `acc_hi` + (`lo_q[0]` ? `mcand` : 0) + 0.
  - `acc_hi`←{`cout`, `sum[31:1]`}; `lo_q`←{`sum[0]`, `lo_q[31:1]`}; `cnt`←`cnt`+1.
  - On the iteration where `cnt`=31: next state is NEG_LO if `neg_p`, else DONE.
- **NEG_LO**: adder computes ~`lo_q`+0+1; `lo_q`←`sum`, `c_q`←`cout`. Next state: NEG_HI.
- **NEG_HI**: adder computes ~`acc_hi`+0+`c_q`; `acc_hi`←`sum`. Next state: DONE.
- **DONE**: `done`=1 for exactly one cycle. Next state: IDLE.
- `hi`/`lo` hold their final value from DONE until the next accepted `start`. They are undefined (intermediate) while `busy` is high in other states.
- Magnitude of 0x80000000 negates to 0x80000000, which is read as an unsigned 2^31. This is correct; no special case.
- A zero product with `neg_p`=1 stays zero (the carry propagates through NEG_HI).

## Timing
- Reset (async, `clr_n`=0):
  - state←IDLE.
  - All registers←0, so `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Reset mid-operation aborts with no `done` pulse.
- Call the start-sampling edge E0. MUL occupies 32 cycles.
- `done` is high in cycle k (the cycle after edge Ek):
  - unsigned, or both operands non-negative: k = 33.
  - add 1 per negated operand and 2 when `neg_p`.
  - maximum k = 36 (one operand negative: 1 + 32 + 2 + 1).
- `start` while `busy`=1 (including the DONE cycle) is ignored, not queued.
- Back-to-back: the earliest re-accept is the IDLE cycle right after DONE.
- `busy` rises in the cycle after E0 and falls in the cycle after DONE.

## Structure
- Shared package `alu_pkg`:
  - state enum, binary encoded: IDLE=0, NEG_A=1, NEG_B=2, MUL=3, NEG_LO=4, NEG_HI=5, DONE=6.
  - `WORD_W`=32, `CNT_W`=6, `MUL_ITERS`=32.
- Single sub-module: one `cla32bit` instance as the shared adder.
- Everything else is in this module: state register, operand mux, shift/negate register updates.

## Test plan
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` in cycle 33; `busy` high for cycles 1–33.
- Signed −3 × 7 (0xFFFFFFFD, 0x00000007) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` in cycle 36.
- Signed 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000; `done` in cycle 35. Signed 0 × −5 → `hi`=`lo`=0.
- `start` pulsed at cycles 5 and 33 during a busy op → ignored. Second op accepted in cycle 34; its result is independent of the first.
- `clr_n` low at cycle 20 → `busy`/`hi`/`lo`/`done` go to 0 immediately. No `done` afterwards. The next `start` yields the correct 7 × 6 = 0x0/0x2A.
- `SIGNED_SUPPORT`=0 with `signed_op`=1, −1 × 2 → `hi`=0x00000001, `lo`=0xFFFFFFFE; `done` in cycle 33.

Source files
------------

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared ALU definitions: word/count widths and the multiplier state encoding.
package alu_pkg;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = 6;
    localparam int MUL_ITERS = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_MUL    = 3'd3,
        ST_NEG_LO = 3'd4,
        ST_NEG_HI = 3'd5,
        ST_DONE   = 3'd6
    } mul_state_t;
endpackage

// File: rtl/cla32bit.sv
`timescale 1ns/1ps
// 32-bit adder: eight 4-bit carry-lookahead groups, group carries rippled.
import alu_pkg::*;

module cla32bit (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output logic [WORD_W-1:0] o_sum,
    output logic              o_cout
);
    localparam int GRPS = WORD_W / 4;

    logic [WORD_W-1:0] w_p;
    logic [WORD_W-1:0] w_g;
    logic [GRPS-1:0]   w_grp_p;
    logic [GRPS-1:0]   w_grp_g;
    logic [GRPS-1:0]   w_gcin;
    logic              w_cout;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    for (genvar gi = 0; gi < GRPS; gi++) begin : g_grp
        logic [3:0] w_gp;
        logic [3:0] w_gg;
        logic [3:0] w_c;
        assign w_gp = w_p[4*gi +: 4];
        assign w_gg = w_g[4*gi +: 4];
        assign w_grp_p[gi] = &w_gp;
        assign w_grp_g[gi] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                           | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
        assign w_c[0] = w_gcin[gi];
        assign w_c[1] = w_gg[0] | (w_gp[0] & w_gcin[gi]);
        assign w_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_gcin[gi]);
        assign w_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                      | (w_gp[2] & w_gp[1] & w_gp[0] & w_gcin[gi]);
        assign o_sum[4*gi +: 4] = w_gp ^ w_c;
    end

    // Ripple the group carries from the group propagate/generate terms.
    always_comb begin
        logic w_c;
        w_gcin = '0;
        w_c    = i_cin;
        for (int i = 0; i < GRPS; i++) begin
            w_gcin[i] = w_c;
            w_c       = w_grp_g[i] | (w_grp_p[i] & w_c);
        end
        w_cout = w_c;
    end

    assign o_cout = w_cout;
endmodule

// File: rtl/mul32_seq_ctrl.sv
`timescale 1ns/1ps
// Sequential 32x32->64 multiplier: operand negation, 32 shift-add steps and
// result negation all share one 32-bit adder.
import alu_pkg::*;

module mul32_seq_ctrl #(
    parameter bit SIGNED_SUPPORT = 1'b1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              signed_op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);
    mul_state_t        r_state, w_nxt;
    logic [WORD_W-1:0] r_mcand, r_acc_hi, r_lo_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_a, r_neg_b, r_neg_p, r_c_q;

    logic [WORD_W-1:0] w_add_a, w_add_b, w_sum;
    logic              w_add_cin, w_cout;
    logic              w_s, w_na, w_nb, w_last;

    assign w_s    = signed_op & SIGNED_SUPPORT;
    assign w_na   = w_s & a[WORD_W-1];
    assign w_nb   = w_s & b[WORD_W-1];
    assign w_last = (r_cnt == CNT_W'(MUL_ITERS - 1));

    cla32bit u_add (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next-state and adder operand selection; negation is ~x + 1 (or + saved carry).
    always_comb begin
        w_nxt     = r_state;
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_nxt = w_na ? ST_NEG_A : (w_nb ? ST_NEG_B : ST_MUL);
            end
            ST_NEG_A: begin
                w_add_a   = ~r_mcand;
                w_add_cin = 1'b1;
                w_nxt     = r_neg_b ? ST_NEG_B : ST_MUL;
            end
            ST_NEG_B: begin
                w_add_a   = ~r_lo_q;
                w_add_cin = 1'b1;
                w_nxt     = ST_MUL;
            end
            ST_MUL: begin
                w_add_a = r_acc_hi;
                w_add_b = r_lo_q[0] ? r_mcand : '0;
                if (w_last)
                    w_nxt = r_neg_p ? ST_NEG_LO : ST_DONE;
            end
            ST_NEG_LO: begin
                w_add_a   = ~r_lo_q;
                w_add_cin = 1'b1;
                w_nxt     = ST_NEG_HI;
            end
            ST_NEG_HI: begin
                w_add_a   = ~r_acc_hi;
                w_add_cin = r_c_q;
                w_nxt     = ST_DONE;
            end
            ST_DONE: w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    // Datapath registers: load on start, then negate / shift-add in place.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_lo_q   <= '0;
            r_cnt    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_neg_p  <= 1'b0;
            r_c_q    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_lo_q   <= b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_neg_a  <= w_na;
                        r_neg_b  <= w_nb;
                        r_neg_p  <= w_na ^ w_nb;
                    end
                end
                ST_NEG_A: r_mcand <= w_sum;
                ST_NEG_B: r_lo_q  <= w_sum;
                ST_MUL: begin
                    r_acc_hi <= {w_cout, w_sum[WORD_W-1:1]};
                    r_lo_q   <= {w_sum[0], r_lo_q[WORD_W-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                end
                ST_NEG_LO: begin
                    r_lo_q <= w_sum;
                    r_c_q  <= w_cout;
                end
                ST_NEG_HI: r_acc_hi <= w_sum;
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign hi   = r_acc_hi;
    assign lo   = r_lo_q;
endmodule

// File: tb/tb_mul32_seq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for mul32_seq_ctrl: signed/unsigned products, done latency,
// ignored starts, async reset abort, and the unsigned-only build.
module tb_mul32_seq_ctrl;
    logic        clk = 1'b0;
    logic        clr_n;
    logic        start, signed_op;
    logic [31:0] a, b;
    logic        busy0, done0, busy1, done1;
    logic [31:0] hi0, lo0, hi1, lo1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_done;

    always #5 clk = ~clk;

    mul32_seq_ctrl #(.SIGNED_SUPPORT(1'b1)) u_dut (
        .clk(clk), .clr_n(clr_n), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
    );

    mul32_seq_ctrl #(.SIGNED_SUPPORT(1'b0)) u_dut_us (
        .clk(clk), .clr_n(clr_n), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present an operation for one cycle; returns in cycle 1 (after E0).
    task automatic issue(input logic sop, input logic [31:0] xa, input logic [31:0] xb);
        start = 1'b1; signed_op = sop; a = xa; b = xb;
        cyc = 0;
        step();
        start = 1'b0;
    endtask

    // Wait for done on the selected instance, checking busy along the way.
    task automatic wait_done(input bit sel, input int exp_k, input logic [31:0] eh,
                             input logic [31:0] el, input string tag);
        while (!(sel ? done1 : done0) && cyc < 60) begin
            chk({tag, "_busy"}, sel ? busy1 : busy0, 1);
            step();
        end
        chk({tag, "_cyc"}, cyc, exp_k);
        chk({tag, "_busy_done"}, sel ? busy1 : busy0, 1);
        chk({tag, "_hi"}, sel ? hi1 : hi0, eh);
        chk({tag, "_lo"}, sel ? lo1 : lo0, el);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        #3;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_hi", hi0, 0);
        chk("rst_lo", lo0, 0);
        @(negedge clk);
        clr_n = 1'b1;
        step();

        // Unsigned max x max, then hold after DONE
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, 33, 32'hFFFF_FFFE, 32'h0000_0001, "u_max");
        step();
        chk("u_max_idle", busy0, 0);
        chk("u_max_nodone", done0, 0);
        chk("u_max_hold_hi", hi0, 32'hFFFF_FFFE);
        chk("u_max_hold_lo", lo0, 32'h0000_0001);

        // Signed -3 x 7
        issue(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(1'b0, 36, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "s_m3x7");
        step();

        // Signed min x min
        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done(1'b0, 35, 32'h4000_0000, 32'h0000_0000, "s_min2");
        step();

        // Signed 0 x -5: zero product with neg_p
        issue(1'b1, 32'h0000_0000, 32'hFFFF_FFFB);
        wait_done(1'b0, 36, 32'h0, 32'h0, "s_0xm5");
        step();

        // Starts during busy (cycle 5) and DONE (cycle 33) are ignored
        issue(1'b0, 32'd5, 32'd3);
        for (int k = 1; k <= 33; k++) begin
            start = (k == 5 || k == 33);
            a = 32'hDEAD_BEEF; b = 32'h0000_1234;
            chk("ign_done", done0, (k == 33));
            step();
        end
        start = 1'b0;
        chk("ign_idle34", busy0, 0);
        chk("ign_hi", hi0, 32'h0);
        chk("ign_lo", lo0, 32'd15);
        issue(1'b0, 32'h1111_1111, 32'h0000_0010);
        wait_done(1'b0, 33, 32'h0000_0001, 32'h1111_1110, "b2b");
        step();

        // Async reset mid-operation
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        while (cyc < 20) step();
        #1 clr_n = 1'b0;
        #1;
        chk("clr_busy", busy0, 0);
        chk("clr_done", done0, 0);
        chk("clr_hi", hi0, 0);
        chk("clr_lo", lo0, 0);
        chk("clr_busy_us", busy1, 0);
        #1 clr_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done0 || done1) n_done++;
        end
        chk("clr_nodone", n_done, 0);
        issue(1'b0, 32'd7, 32'd6);
        wait_done(1'b0, 33, 32'h0, 32'h0000_002A, "clr_7x6");
        step();

        // Unsigned-only build ignores signed_op; signed build negates
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(1'b1, 33, 32'h0000_0001, 32'hFFFF_FFFE, "us_m1x2");
        wait_done(1'b0, 36, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "s_m1x2");
        step();
        chk("end_idle", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
